bus_master_arbiter: RTL and testbench
=====================================

// Module: bus_master_arbiter
// PURPOSE
// - Round-robin arbiter sharing the single Avalon-MM system bus among NUM_MASTERS requesters (CPU I-port, CPU D-port, DMA).
// - Sequences each granted transaction to completion (read/write bursts).
// - Watchdogs every transaction; a timeout or error response is reported to the interrupt controller's bad-address capture (badAddr/badAddrValid/badAddrAck).
// PARAMETERS
// - NUM_MASTERS     3    number of requesting masters, index 0..NUM_MASTERS-1
// - TIMEOUT_CYCLES  255  idle cycles without slave progress before a transaction is aborted
// PORTS
// - clk                    in   1        clock
// - rst_n                  in   1        synchronous, active-low reset
// - m_address              in   NM*30    word addresses, master i at [30*i +: 30]
// - m_writedata            in   NM*32    per-master write data
// - m_byteenable           in   NM*4     per-master byte enables
// - m_burstcount           in   NM*5     per-master burst length; 0 is treated as 1
// - m_read / m_write       in   NM       per-master command strobes, held until waitrequest low
// - m_waitrequest          out  NM       per-master stall
// - m_readdata             out  32       broadcast read data
// - m_readdatavalid        out  NM       per-master read beat valid
// - m_writeresponsevalid   out  NM       per-master write response valid
// - m_response             out  2        broadcast response code
// - bus_address/writedata/byteenable/burstcount/read/write  out  30/32/4/5/1/1  to slaves
// - s_waitrequest/readdata/readdatavalid/writeresponsevalid/response  in  1/32/1/1/2  from slaves
// - badAddr                out  32       byte address of failed transaction = {address, 2'b00}
// - badAddrValid           out  1        held until badAddrAck
// - badAddrAck             in   1        interrupt controller capture acknowledge
// BEHAVIOUR
// - Reset values
//   - Outputs: all m_waitrequest=1, every valid and strobe 0, data/address 0, badAddrValid=0.
//   - State: FSM=IDLE; last_grant=NUM_MASTERS-1, so master 0 has highest priority.
// - Reset mid-transaction: abandon the transaction immediately. No response or report is generated.
// - FSM states: IDLE, CMD, RESP, REPORT.
// - IDLE
//   - Pick the first requester (m_read|m_write) scanning from last_grant+1 modulo NM.
//   - Register grant, address, burstcount and direction; last_grant<=grant; go to CMD.
//   - If read and write are both high, treat the command as a read.
//   - Latency: the command reaches the bus one cycle after it is first seen.
// - CMD
//   - Drive the granted master's fields on bus_*. m_waitrequest[g]=s_waitrequest; every other master sees 1.
//   - Read: command accepted when s_waitrequest=0 -> RESP with beats_left=burstcount.
//   - Write: each beat is accepted when s_waitrequest=0; beats_left decrements per accepted beat.
//   - Write: after the last beat -> RESP, expecting one writeresponsevalid.
// - RESP
//   - Route s_readdatavalid / s_writeresponsevalid to the granted master only. readdata and response pass through combinationally.
//   - Read: done after beats_left readdatavalid beats.
//   - Write: done after one writeresponsevalid.
//   - If the final beat's response is nonzero -> REPORT; otherwise -> IDLE.
// - Timeout
//   - 8-bit counter, cleared on entering CMD and on every accepted beat or response beat.
//   - At count==TIMEOUT_CYCLES, in CMD or RESP:
//     - deassert bus_read/bus_write;
//     - pulse the granted master's readdatavalid (read) or writeresponsevalid (write) once, with readdata=0 and response=2'b11;
//     - go to REPORT.
// - REPORT
//   - badAddr={latched address,2'b00}; badAddrValid=1 until the cycle after badAddrAck=1, then -> IDLE.
//   - Other masters remain stalled throughout REPORT.
// - Bubble: there is one IDLE cycle between back-to-back transactions. The same master may win again only if no other master is requesting.
// - A slave response while in IDLE is spurious and is dropped.
// STRUCTURE
// - Shared package bus_pkg
//   - AW=30, DW=32, BCW=5
//   - resp_t codes: OKAY=2'b00, SLVERR=2'b10, DECODEERR=2'b11
//   - arb_state_t enum {IDLE,CMD,RESP,REPORT}
// - Sub-module rr_pick: combinational (req[NM], last[$clog2(NM)]) -> (valid, idx).
// TESTING
// 1. Reset: rst_n=0 for 3 cycles, all masters requesting -> m_waitrequest=3'b111, no bus strobe, badAddrValid=0.
// 2. Round robin: all 3 masters read continuously, burst 1 -> grants 0,1,2,0; each gets exactly 1 readdatavalid with its slave data.
// 3. Read burst: master 1 reads 0x3E00C000, burstcount 4; slave returns 4 beats with gaps -> master 1 gets 4 beats in order, others 0.
// 4. Write burst: master 2 writes 3 beats, slave stalls beat 2 for 5 cycles -> 3 bus beats, one writeresponsevalid to master 2.
// 5. Timeout: master 0 reads 0x00001234, no slave answers -> after 255 cycles, response=2'b11 and readdata=0; badAddr=0x000048D0 until ack.
// 6. Error response: slave returns response 2'b11 on write -> forwarded to master; badAddrValid rises; master 1 stalled until badAddrAck.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus arbiter: bus widths, response codes,
// arbiter FSM states and a burst-length helper.
// No ports; imported by bus_master_arbiter and its sub-modules.
package bus_pkg;

    localparam int AW  = 30;        // word address width
    localparam int DW  = 32;        // data width
    localparam int BEW = DW / 8;    // byte-enable width
    localparam int BCW = 5;         // burstcount width

    typedef enum logic [1:0] {
        OKAY      = 2'b00,
        SLVERR    = 2'b10,
        DECODEERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RESP,
        REPORT
    } arb_state_t;

    // A burstcount of zero is issued as a single beat.
    function automatic logic [BCW-1:0] norm_burst(input logic [BCW-1:0] bc);
        return (bc == '0) ? BCW'(1) : bc;
    endfunction

endpackage

// File: rtl/bus_master_arbiter_rr_pick.sv
// Round-robin requester picker: first set bit of i_req scanning upward from
// i_last+1 (mod NM), wrapping so that i_last itself is considered last.
// Ports: i_req (request vector), i_last (previous grant) -> o_valid, o_idx.
module rr_pick #(
    parameter int NM = 3,
    parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] i_req,
    input  logic [LW-1:0] i_last,
    output logic          o_valid,
    output logic [LW-1:0] o_idx
);

    int w_cand;

    // Scan from the farthest candidate to the nearest; the last hit wins,
    // which is the requester closest after i_last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int off = NM; off >= 1; off--) begin
            w_cand = (int'(i_last) + off) % NM;
            if (i_req[LW'(w_cand)]) begin
                o_valid = 1'b1;
                o_idx   = LW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin Avalon-MM arbiter for NUM_MASTERS masters onto one system bus,
// with a per-transaction watchdog and bad-address reporting.
// Ports: m_* (per-master Avalon-MM slave side, packed by master index),
//        bus_*/s_* (shared Avalon-MM master side), badAddr/badAddrValid/badAddrAck
//        (interrupt controller capture handshake), clk, rst_n (sync, active-low).
// Latency: a command reaches the bus one cycle after it is first seen; one IDLE
// bubble separates transactions. Non-granted masters are held in waitrequest.
module bus_master_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_MASTERS*AW-1:0]    m_address,
    input  logic [NUM_MASTERS*DW-1:0]    m_writedata,
    input  logic [NUM_MASTERS*BEW-1:0]   m_byteenable,
    input  logic [NUM_MASTERS*BCW-1:0]   m_burstcount,
    input  logic [NUM_MASTERS-1:0]       m_read,
    input  logic [NUM_MASTERS-1:0]       m_write,
    output logic [NUM_MASTERS-1:0]       m_waitrequest,
    output logic [DW-1:0]                m_readdata,
    output logic [NUM_MASTERS-1:0]       m_readdatavalid,
    output logic [NUM_MASTERS-1:0]       m_writeresponsevalid,
    output logic [1:0]                   m_response,
    output logic [AW-1:0]                bus_address,
    output logic [DW-1:0]                bus_writedata,
    output logic [BEW-1:0]               bus_byteenable,
    output logic [BCW-1:0]               bus_burstcount,
    output logic                         bus_read,
    output logic                         bus_write,
    input  logic                         s_waitrequest,
    input  logic [DW-1:0]                s_readdata,
    input  logic                         s_readdatavalid,
    input  logic                         s_writeresponsevalid,
    input  logic [1:0]                   s_response,
    output logic [31:0]                  badAddr,
    output logic                         badAddrValid,
    input  logic                         badAddrAck
);

    localparam int              GW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [7:0]      TO_LIMIT   = 8'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0]   LAST_RESET = GW'(NUM_MASTERS - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [GW-1:0]     r_grant;
    logic [GW-1:0]     r_last_grant;
    logic [AW-1:0]     r_addr;
    logic [BCW-1:0]    r_burst;
    logic [BCW-1:0]    r_beats_left;
    logic              r_is_write;
    logic [7:0]        r_timer;

    logic [NUM_MASTERS-1:0] w_req;
    logic                   w_pick_vld;
    logic [GW-1:0]          w_pick_idx;
    logic [AW-1:0]          w_p_addr;
    logic [BCW-1:0]         w_p_burst;
    logic                   w_p_read;
    logic [DW-1:0]          w_g_wdata;
    logic [BEW-1:0]         w_g_be;
    logic                   w_g_write;
    logic                   w_timeout;
    logic                   w_cmd_acc;
    logic                   w_resp_beat;
    logic                   w_last_beat;

    assign w_req = m_read | m_write;

    rr_pick #(
        .NM (NUM_MASTERS),
        .LW (GW)
    ) u_pick (
        .i_req   (w_req),
        .i_last  (r_last_grant),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    // Fields of the master being picked (IDLE) and of the granted master (CMD).
    assign w_p_addr  = m_address[int'(w_pick_idx) * AW +: AW];
    assign w_p_burst = m_burstcount[int'(w_pick_idx) * BCW +: BCW];
    assign w_p_read  = m_read[w_pick_idx];
    assign w_g_wdata = m_writedata[int'(r_grant) * DW +: DW];
    assign w_g_be    = m_byteenable[int'(r_grant) * BEW +: BEW];
    assign w_g_write = m_write[r_grant];

    assign w_timeout   = ((r_state == CMD) || (r_state == RESP)) && (r_timer == TO_LIMIT);
    // A write beat only counts when the master is actually presenting one;
    // masters may idle between beats of a write burst.
    assign w_cmd_acc   = (r_state == CMD) && !w_timeout && !s_waitrequest &&
                         (r_is_write ? w_g_write : 1'b1);
    assign w_resp_beat = (r_state == RESP) && !w_timeout &&
                         (r_is_write ? s_writeresponsevalid : s_readdatavalid);
    assign w_last_beat = (r_beats_left == BCW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= LAST_RESET;
            r_addr       <= '0;
            r_burst      <= '0;
            r_beats_left <= '0;
            r_is_write   <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_grant      <= w_pick_idx;
                        r_last_grant <= w_pick_idx;
                        r_addr       <= w_p_addr;
                        r_burst      <= norm_burst(w_p_burst);
                        r_beats_left <= norm_burst(w_p_burst);
                        // Read wins when both strobes are high.
                        r_is_write   <= !w_p_read;
                        r_timer      <= '0;
                    end
                end
                CMD, RESP: begin
                    if (w_cmd_acc || w_resp_beat) begin
                        r_timer <= '0;
                    end else if (!w_timeout) begin
                        r_timer <= r_timer + 8'd1;
                    end
                    // Writes count down beats in CMD, reads count down in RESP.
                    if ((w_cmd_acc && r_is_write) || (w_resp_beat && !r_is_write)) begin
                        r_beats_left <= r_beats_left - BCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        m_waitrequest        = '1;
        m_readdatavalid      = '0;
        m_writeresponsevalid = '0;
        m_readdata           = '0;
        m_response           = OKAY;
        bus_address          = '0;
        bus_writedata        = '0;
        bus_byteenable       = '0;
        bus_burstcount       = '0;
        bus_read             = 1'b0;
        bus_write            = 1'b0;
        badAddr              = '0;
        badAddrValid         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = CMD;
                end
            end

            CMD, RESP: begin
                if (w_timeout) begin
                    // Abort: strobes stay low, the master gets one synthetic
                    // error beat with zero data.
                    m_response = DECODEERR;
                    if (r_is_write) begin
                        m_writeresponsevalid[r_grant] = 1'b1;
                    end else begin
                        m_readdatavalid[r_grant] = 1'b1;
                    end
                    w_state_nxt = REPORT;
                end else if (r_state == CMD) begin
                    bus_address    = r_addr;
                    bus_burstcount = r_burst;
                    bus_byteenable = w_g_be;
                    if (r_is_write) begin
                        bus_write     = w_g_write;
                        bus_writedata = w_g_wdata;
                    end else begin
                        bus_read = 1'b1;
                    end
                    m_waitrequest[r_grant] = s_waitrequest;
                    if (w_cmd_acc && (!r_is_write || w_last_beat)) begin
                        w_state_nxt = RESP;
                    end
                end else begin
                    m_readdata = s_readdata;
                    m_response = s_response;
                    if (r_is_write) begin
                        m_writeresponsevalid[r_grant] = s_writeresponsevalid;
                    end else begin
                        m_readdatavalid[r_grant] = s_readdatavalid;
                    end
                    if (w_resp_beat && (r_is_write || w_last_beat)) begin
                        w_state_nxt = (s_response != OKAY) ? REPORT : IDLE;
                    end
                end
            end

            REPORT: begin
                badAddr      = {r_addr, 2'b00};
                badAddrValid = 1'b1;
                if (badAddrAck) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed self-checking bench for bus_master_arbiter (3 masters, timeout 255).
// Each scenario task drives masters and a small slave model and checks inline.
// Inputs change at negedge; outputs are sampled 1 time unit later.
module tb_bus_master_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [89:0]  m_address;
    logic [95:0]  m_writedata;
    logic [11:0]  m_byteenable;
    logic [14:0]  m_burstcount;
    logic [2:0]   m_read;
    logic [2:0]   m_write;
    logic [2:0]   m_waitrequest;
    logic [31:0]  m_readdata;
    logic [2:0]   m_readdatavalid;
    logic [2:0]   m_writeresponsevalid;
    logic [1:0]   m_response;
    logic [29:0]  bus_address;
    logic [31:0]  bus_writedata;
    logic [3:0]   bus_byteenable;
    logic [4:0]   bus_burstcount;
    logic         bus_read;
    logic         bus_write;
    logic         s_waitrequest;
    logic [31:0]  s_readdata;
    logic         s_readdatavalid;
    logic         s_writeresponsevalid;
    logic [1:0]   s_response;
    logic [31:0]  badAddr;
    logic         badAddrValid;
    logic         badAddrAck;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_master_arbiter #(
        .NUM_MASTERS    (3),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .m_address            (m_address),
        .m_writedata          (m_writedata),
        .m_byteenable         (m_byteenable),
        .m_burstcount         (m_burstcount),
        .m_read               (m_read),
        .m_write              (m_write),
        .m_waitrequest        (m_waitrequest),
        .m_readdata           (m_readdata),
        .m_readdatavalid      (m_readdatavalid),
        .m_writeresponsevalid (m_writeresponsevalid),
        .m_response           (m_response),
        .bus_address          (bus_address),
        .bus_writedata        (bus_writedata),
        .bus_byteenable       (bus_byteenable),
        .bus_burstcount       (bus_burstcount),
        .bus_read             (bus_read),
        .bus_write            (bus_write),
        .s_waitrequest        (s_waitrequest),
        .s_readdata           (s_readdata),
        .s_readdatavalid      (s_readdatavalid),
        .s_writeresponsevalid (s_writeresponsevalid),
        .s_response           (s_response),
        .badAddr              (badAddr),
        .badAddrValid         (badAddrValid),
        .badAddrAck           (badAddrAck)
    );

    task automatic clear_inputs();
        m_address            = '0;
        m_writedata          = '0;
        m_byteenable         = '0;
        m_burstcount         = '0;
        m_read               = '0;
        m_write              = '0;
        s_waitrequest        = 1'b0;
        s_readdata           = '0;
        s_readdatavalid      = 1'b0;
        s_writeresponsevalid = 1'b0;
        s_response           = 2'b00;
        badAddrAck           = 1'b0;
    endtask

    task automatic set_master(input int i, input logic [29:0] addr, input logic [4:0] bc);
        m_address[i*30 +: 30]  = addr;
        m_burstcount[i*5 +: 5] = bc;
        m_byteenable[i*4 +: 4] = 4'hF;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        m_read = 3'b111;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (m_waitrequest !== 3'b111) begin
            n_bad++; $display("FAIL reset_waitrequest: got %b want 111", m_waitrequest);
        end
        n_cmp++;
        if ({bus_read, bus_write} !== 2'b00) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 00", {bus_read, bus_write});
        end
        n_cmp++;
        if (badAddrValid !== 1'b0) begin
            n_bad++; $display("FAIL reset_badaddrvalid: got %b want 0", badAddrValid);
        end
        n_cmp++;
        if ({m_readdatavalid, m_writeresponsevalid, bus_address} !== 36'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", {m_readdatavalid, m_writeresponsevalid, bus_address});
        end
        m_read = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset in the middle of a read burst, then a spurious slave beat in IDLE.
    task automatic test_reset_mid();
        set_master(2, 30'h0000_0300, 5'd2);
        @(negedge clk); m_read[2] = 1'b1; #1;
        @(negedge clk); #1;
        n_cmp++;
        if (m_waitrequest !== 3'b011) begin
            n_bad++; $display("FAIL rmid_accept: got %b want 011", m_waitrequest);
        end
        @(negedge clk); m_read[2] = 1'b0; rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1; s_readdatavalid = 1'b1; s_readdata = 32'h5555_5555; #1;
        n_cmp++;
        if ({m_waitrequest, m_readdatavalid, badAddrValid} !== 7'b111_000_0) begin
            n_bad++; $display("FAIL rmid_abandon: got %b want 1110000", {m_waitrequest, m_readdatavalid, badAddrValid});
        end
        @(negedge clk); s_readdatavalid = 1'b0; #1;
        n_cmp++;
        if ({bus_read, m_readdatavalid, badAddrValid} !== 5'b0) begin
            n_bad++; $display("FAIL rmid_idle: got %b want 00000", {bus_read, m_readdatavalid, badAddrValid});
        end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int rdv_cnt[3];
        int exp_g[4];
        int exp_cnt[3];
        logic pend;
        logic [31:0] pend_data;
        int g;
        exp_g   = '{0, 1, 2, 0};
        exp_cnt = '{2, 1, 1};
        rdv_cnt = '{0, 0, 0};
        pend = 1'b0;
        pend_data = '0;
        for (int i = 0; i < 3; i++) set_master(i, 30'h100 + 30'(i), 5'd1);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            m_read          = (grants.size() >= 4) ? 3'b000 : 3'b111;
            s_readdatavalid = pend;
            s_readdata      = pend ? pend_data : 32'h0;
            pend = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
                if (m_readdatavalid[i]) begin
                    rdv_cnt[i]++;
                    n_cmp++;
                    if (m_readdata !== 32'hC000_0100 + 32'(i)) begin
                        n_bad++; $display("FAIL rr_data_m%0d: got %h want %h", i, m_readdata, 32'hC000_0100 + 32'(i));
                    end
                end
            end
            if (bus_read && !s_waitrequest) begin
                g = -1;
                for (int i = 0; i < 3; i++) if (!m_waitrequest[i]) g = i;
                grants.push_back(g);
                pend = 1'b1;
                pend_data = {2'b11, bus_address};
            end
        end
        n_cmp++;
        if (grants.size() != 4) begin
            n_bad++; $display("FAIL rr_grant_count: got %0d want 4", grants.size());
        end
        for (int k = 0; k < 4 && k < grants.size(); k++) begin
            n_cmp++;
            if (grants[k] != exp_g[k]) begin
                n_bad++; $display("FAIL rr_grant_%0d: got %0d want %0d", k, grants[k], exp_g[k]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdv_cnt[i] != exp_cnt[i]) begin
                n_bad++; $display("FAIL rr_beats_m%0d: got %0d want %0d", i, rdv_cnt[i], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_read_burst();
        logic [7:0] pat;
        int acc_c, sent, rcv, other;
        pat = 8'b1001_1010;
        acc_c = -1; sent = 0; rcv = 0; other = 0;
        set_master(1, 30'h3E00_C000, 5'd4);
        @(negedge clk); m_read[1] = 1'b1; #1;
        n_cmp++;
        if (bus_read !== 1'b0) begin
            n_bad++; $display("FAIL rb_latency0: got bus_read=%b want 0", bus_read);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            s_readdatavalid = (acc_c >= 0) && (c - acc_c <= 7) && (c > acc_c) && pat[c - acc_c] && (sent < 4);
            s_readdata = 32'hA0 + 32'(sent);
            if (s_readdatavalid) sent++;
            #1;
            if (c == 0) begin
                n_cmp++;
                if (bus_read !== 1'b1) begin
                    n_bad++; $display("FAIL rb_latency1: got bus_read=%b want 1", bus_read);
                end
            end
            if (m_readdatavalid[1]) begin
                n_cmp++;
                if (m_readdata !== 32'hA0 + 32'(rcv)) begin
                    n_bad++; $display("FAIL rb_beat_%0d: got %h want %h", rcv, m_readdata, 32'hA0 + 32'(rcv));
                end
                rcv++;
            end
            if (m_readdatavalid[0] || m_readdatavalid[2]) other++;
            if (bus_read && !m_waitrequest[1] && acc_c < 0) begin
                acc_c = c;
                m_read[1] = 1'b0;
                n_cmp++;
                if ({bus_address, bus_burstcount} !== {30'h3E00_C000, 5'd4}) begin
                    n_bad++; $display("FAIL rb_cmd: got %h/%0d want 3e00c000/4", bus_address, bus_burstcount);
                end
            end
        end
        n_cmp++;
        if (rcv != 4 || other != 0) begin
            n_bad++; $display("FAIL rb_counts: got m1=%0d others=%0d want 4/0", rcv, other);
        end
        n_cmp++;
        if ({m_waitrequest, bus_read} !== 4'b1110) begin
            n_bad++; $display("FAIL rb_done_idle: got %b want 1110", {m_waitrequest, bus_read});
        end
    endtask

    task automatic test_write_burst();
        logic [31:0] wd[3];
        int mbeat, sbeat, stall, wrv2, wrv_other;
        logic resp_pend;
        wd = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};
        mbeat = 0; sbeat = 0; stall = 0; wrv2 = 0; wrv_other = 0; resp_pend = 1'b0;
        set_master(2, 30'h0000_0200, 5'd3);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            m_write[2]           = (mbeat < 3);
            m_writedata[64 +: 32] = wd[(mbeat < 3) ? mbeat : 2];
            s_waitrequest        = (sbeat == 1) && (stall < 5);
            s_writeresponsevalid = resp_pend;
            s_response           = 2'b00;
            resp_pend = 1'b0;
            #1;
            if (bus_write && s_waitrequest) stall++;
            if (bus_write && !s_waitrequest) begin
                n_cmp++;
                if ({bus_writedata, bus_burstcount} !== {wd[sbeat], 5'd3}) begin
                    n_bad++; $display("FAIL wb_beat_%0d: got %h/%0d want %h/3", sbeat, bus_writedata, bus_burstcount, wd[sbeat]);
                end
                sbeat++;
                if (sbeat == 3) resp_pend = 1'b1;
            end
            if (m_write[2] && !m_waitrequest[2]) mbeat++;
            if (m_writeresponsevalid[2]) begin
                wrv2++;
                n_cmp++;
                if (m_response !== 2'b00) begin
                    n_bad++; $display("FAIL wb_resp_code: got %b want 00", m_response);
                end
            end
            if (m_writeresponsevalid[1:0] != 2'b00) wrv_other++;
        end
        n_cmp++;
        if (sbeat != 3 || stall != 5) begin
            n_bad++; $display("FAIL wb_bus_beats: got beats=%0d stalls=%0d want 3/5", sbeat, stall);
        end
        n_cmp++;
        if (wrv2 != 1 || wrv_other != 0) begin
            n_bad++; $display("FAIL wb_wrresp: got m2=%0d others=%0d want 1/0", wrv2, wrv_other);
        end
        s_waitrequest = 1'b0;
    endtask

    task automatic test_timeout();
        int rd_high;
        logic seen;
        rd_high = 0; seen = 1'b0;
        set_master(0, 30'h0000_1234, 5'd1);
        s_waitrequest = 1'b1;
        s_readdata    = 32'hFFFF_FFFF;
        @(negedge clk); m_read[0] = 1'b1; #1;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk); #1;
            if (bus_read) rd_high++;
            if (m_readdatavalid !== 3'b000) begin
                seen = 1'b1;
                n_cmp++;
                if ({m_readdatavalid, m_response, m_readdata} !== {3'b001, 2'b11, 32'h0}) begin
                    n_bad++; $display("FAIL to_pulse: got v=%b r=%b d=%h want 001/11/0", m_readdatavalid, m_response, m_readdata);
                end
                n_cmp++;
                if ({m_waitrequest, bus_read} !== 4'b1110) begin
                    n_bad++; $display("FAIL to_abort: got %b want 1110", {m_waitrequest, bus_read});
                end
                m_read[0] = 1'b0;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL to_no_pulse: got none within 400 cycles want one");
        end
        n_cmp++;
        if (rd_high != 255) begin
            n_bad++; $display("FAIL to_cycles: got %0d want 255", rd_high);
        end
        s_waitrequest = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({badAddrValid, badAddr} !== {1'b1, 32'h0000_48D0}) begin
                n_bad++; $display("FAIL to_report_%0d: got %b/%h want 1/000048d0", k, badAddrValid, badAddr);
            end
        end
        @(negedge clk); badAddrAck = 1'b1; #1;
        n_cmp++;
        if (badAddrValid !== 1'b1) begin
            n_bad++; $display("FAIL to_ack_cycle: got %b want 1", badAddrValid);
        end
        @(negedge clk); badAddrAck = 1'b0; #1;
        n_cmp++;
        if (badAddrValid !== 1'b0) begin
            n_bad++; $display("FAIL to_after_ack: got %b want 0", badAddrValid);
        end
    endtask

    task automatic test_error_resp();
        set_master(0, 30'h0000_0ABC, 5'd1);
        m_writedata[0 +: 32] = 32'hCAFE_F00D;
        set_master(1, 30'h0000_0444, 5'd1);
        @(negedge clk); m_write[0] = 1'b1; #1;
        @(negedge clk); m_read[1] = 1'b1; #1;
        n_cmp++;
        if ({m_waitrequest, bus_write, bus_writedata} !== {3'b110, 1'b1, 32'hCAFE_F00D}) begin
            n_bad++; $display("FAIL er_cmd: got %b/%b/%h want 110/1/cafef00d", m_waitrequest, bus_write, bus_writedata);
        end
        @(negedge clk); m_write[0] = 1'b0; s_writeresponsevalid = 1'b1; s_response = 2'b11; #1;
        n_cmp++;
        if ({m_writeresponsevalid, m_response} !== {3'b001, 2'b11}) begin
            n_bad++; $display("FAIL er_forward: got %b/%b want 001/11", m_writeresponsevalid, m_response);
        end
        @(negedge clk); s_writeresponsevalid = 1'b0; s_response = 2'b00; #1;
        n_cmp++;
        if ({badAddrValid, badAddr} !== {1'b1, 32'h0000_2AF0}) begin
            n_bad++; $display("FAIL er_report: got %b/%h want 1/00002af0", badAddrValid, badAddr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({m_waitrequest, bus_read, badAddrValid} !== 5'b1110_1) begin
                n_bad++; $display("FAIL er_stall_%0d: got %b want 11101", k, {m_waitrequest, bus_read, badAddrValid});
            end
        end
        @(negedge clk); badAddrAck = 1'b1; #1;
        n_cmp++;
        if ({m_waitrequest, badAddrValid} !== 4'b1111) begin
            n_bad++; $display("FAIL er_ack_cycle: got %b want 1111", {m_waitrequest, badAddrValid});
        end
        @(negedge clk); badAddrAck = 1'b0; #1;
        n_cmp++;
        if ({badAddrValid, bus_read} !== 2'b00) begin
            n_bad++; $display("FAIL er_bubble: got %b want 00", {badAddrValid, bus_read});
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({bus_read, bus_address, m_waitrequest} !== {1'b1, 30'h0000_0444, 3'b101}) begin
            n_bad++; $display("FAIL er_next_grant: got %b/%h/%b want 1/444/101", bus_read, bus_address, m_waitrequest);
        end
        m_read[1] = 1'b0;
        @(negedge clk); s_readdatavalid = 1'b1; s_readdata = 32'h1234_5678; #1;
        n_cmp++;
        if ({m_readdatavalid, m_readdata} !== {3'b010, 32'h1234_5678}) begin
            n_bad++; $display("FAIL er_m1_data: got %b/%h want 010/12345678", m_readdatavalid, m_readdata);
        end
        @(negedge clk); s_readdatavalid = 1'b0; #1;
        n_cmp++;
        if ({badAddrValid, m_waitrequest} !== 4'b0111) begin
            n_bad++; $display("FAIL er_final_idle: got %b want 0111", {badAddrValid, m_waitrequest});
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_reset_mid();
        clear_inputs(); repeat (2) @(negedge clk);
        test_round_robin();
        clear_inputs(); repeat (2) @(negedge clk);
        test_read_burst();
        clear_inputs(); repeat (2) @(negedge clk);
        test_write_burst();
        clear_inputs(); repeat (2) @(negedge clk);
        test_timeout();
        clear_inputs(); repeat (2) @(negedge clk);
        test_error_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
